// File: rtl/int_gateway_bank.sv
// int_gateway_bank: per-source interrupt gateway with a claim/complete handshake.
// Each source runs its own IDLE/PEND/SERV state machine. The pending source with the
// lowest index is offered for claiming (fixed priority).
//
// Ports:
//   clock          - single clock; all state updates on its rising edge
//   reset          - synchronous, active-high
//   int_in         - synchronized interrupt levels, one bit per source
//   claim_valid    - at least one source is pending
//   claim_id       - lowest pending index (0 when nothing is pending)
//   claim_ready    - consumer accepts the offered claim
//   complete_valid - consumer signals end of service for complete_id
//   complete_id    - source being completed
//   pending        - per-source PEND state (registered)
//   in_service     - per-source SERV state (registered)
//
// Build option: define INT_GATEWAY_EDGE_EN to select edge-triggered sources. In that
// mode each source also keeps a one-deep latch for an edge that arrives while it is
// pending or in service. When the macro is not defined, sources are level-triggered.
module int_gateway_bank #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] int_in,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               claim_ready,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);

  typedef enum logic [1:0] {StIdle, StPend, StServ} state_e;

  state_e             state_q [NUM_SRC];
  state_e             state_d [NUM_SRC];
  logic [NUM_SRC-1:0] pending_q, in_service_q;
  logic [NUM_SRC-1:0] trig;
  logic [NUM_SRC-1:0] comp_hit;
  logic               claim_go;

`ifdef INT_GATEWAY_EDGE_EN
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] latch_q, latch_d;
  assign trig = int_in & ~prev_q;
`else
  assign trig = int_in;
`endif

  // Fixed priority: scan downward so the lowest pending index wins.
  always_comb begin
    claim_valid = |pending_q;
    claim_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) claim_id = ID_W'(i);
    end
  end

  assign claim_go = claim_valid & claim_ready;

  // A complete_id outside 0..NUM_SRC-1 never matches, so it is ignored.
  always_comb begin
    comp_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      comp_hit[i] = complete_valid && (complete_id == ID_W'(i));
    end
  end

  always_comb begin
`ifdef INT_GATEWAY_EDGE_EN
    latch_d = latch_q;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (trig[i]) state_d[i] = StPend;
        end
        StPend: begin
          if (claim_go && (claim_id == ID_W'(i))) state_d[i] = StServ;
`ifdef INT_GATEWAY_EDGE_EN
          if (trig[i]) latch_d[i] = 1'b1;
`endif
        end
        StServ: begin
`ifdef INT_GATEWAY_EDGE_EN
          // A stored edge, or one that arrives on the completing edge, sends the
          // source straight back to PEND.
          if (comp_hit[i]) begin
            state_d[i] = (latch_q[i] || trig[i]) ? StPend : StIdle;
            latch_d[i] = 1'b0;
          end else if (trig[i]) begin
            latch_d[i] = 1'b1;
          end
`else
          if (comp_hit[i]) state_d[i] = StIdle;
`endif
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) state_q[i] <= StIdle;
      pending_q    <= '0;
      in_service_q <= '0;
`ifdef INT_GATEWAY_EDGE_EN
      prev_q       <= '0;
      latch_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i]      <= state_d[i];
        pending_q[i]    <= (state_d[i] == StPend);
        in_service_q[i] <= (state_d[i] == StServ);
      end
`ifdef INT_GATEWAY_EDGE_EN
      prev_q  <= int_in;
      latch_q <= latch_d;
`endif
    end
  end

  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_gateway_bank.sv
module tb_int_gateway_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] int_in;
  logic       claim_ready, complete_valid;
  logic [1:0] complete_id;

  logic       cv4, cv3;
  logic [1:0] cid4, cid3;
  logic [3:0] pend4, serv4;
  logic [2:0] pend3, serv3;

  int total = 0;
  int bad   = 0;

  // Reference state per instance: 0 = idle, 1 = pending, 2 = in service.
  int m_st   [2][4];
  bit m_prev [2][4];
  bit m_lat  [2][4];

  always #5 clock = ~clock;

  int_gateway_bank #(.NUM_SRC(4), .ID_W(2)) dut4 (
    .clock          (clock),
    .reset          (reset),
    .int_in         (int_in),
    .claim_valid    (cv4),
    .claim_id       (cid4),
    .claim_ready    (claim_ready),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .pending        (pend4),
    .in_service     (serv4)
  );

  int_gateway_bank #(.NUM_SRC(3), .ID_W(2)) dut3 (
    .clock          (clock),
    .reset          (reset),
    .int_in         (int_in[2:0]),
    .claim_valid    (cv3),
    .claim_id       (cid3),
    .claim_ready    (claim_ready),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .pending        (pend3),
    .in_service     (serv3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nsrc(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int offered(input int k);
    for (int i = 0; i < nsrc(k); i++) if (m_st[k][i] == 1) return i;
    return -1;
  endfunction

  function automatic logic [3:0] mask_of(input int k, input int v);
    logic [3:0] m = '0;
    for (int i = 0; i < nsrc(k); i++) m[i] = (m_st[k][i] == v);
    return m;
  endfunction

  task automatic model_edge(input int k);
    int n, off, c;
    int nxt [4];
    bit trig [4];
    bit done_c [4];
    n = nsrc(k);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_st[k][i] = 0; m_prev[k][i] = 0; m_lat[k][i] = 0;
      end
      return;
    end
    off = offered(k);
    for (int i = 0; i < n; i++) begin
`ifdef INT_GATEWAY_EDGE_EN
      trig[i] = int_in[i] && !m_prev[k][i];
`else
      trig[i] = int_in[i];
`endif
      nxt[i] = m_st[k][i];
      done_c[i] = 0;
      if (m_st[k][i] == 0 && trig[i]) nxt[i] = 1;
    end
    if (off >= 0 && claim_ready) nxt[off] = 2;
    c = int'(complete_id);
    if (complete_valid && c < n && m_st[k][c] == 2) begin
      done_c[c] = 1;
`ifdef INT_GATEWAY_EDGE_EN
      nxt[c] = (m_lat[k][c] || trig[c]) ? 1 : 0;
      m_lat[k][c] = 0;
`else
      nxt[c] = 0;
`endif
    end
    for (int i = 0; i < n; i++) begin
`ifdef INT_GATEWAY_EDGE_EN
      if (m_st[k][i] != 0 && trig[i] && !done_c[i]) m_lat[k][i] = 1;
      m_prev[k][i] = int_in[i];
`endif
      m_st[k][i] = nxt[i];
    end
  endtask

  task automatic compare_all();
    int o4, o3;
    o4 = offered(0);
    o3 = offered(1);
    check("pend4", 32'(pend4), 32'(mask_of(0, 1)));
    check("serv4", 32'(serv4), 32'(mask_of(0, 2)));
    check("cv4", 32'(cv4), (o4 >= 0) ? 32'd1 : 32'd0);
    check("cid4", 32'(cid4), (o4 >= 0) ? 32'(o4) : 32'd0);
    check("pend3", 32'(pend3), 32'(mask_of(1, 1)));
    check("serv3", 32'(serv3), 32'(mask_of(1, 2)));
    check("cv3", 32'(cv3), (o3 >= 0) ? 32'd1 : 32'd0);
    check("cid3", 32'(cid3), (o3 >= 0) ? 32'(o3) : 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    int_in = '0; claim_ready = 0; complete_valid = 0; complete_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    int_in = 4'hf;  // ignored while in reset
    claim_ready = 1; complete_valid = 0; complete_id = '0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) begin
      m_st[i][j] = 0; m_prev[i][j] = 0; m_lat[i][j] = 0;
    end
    step();
    check("rst_pend", 32'(pend4), 32'd0);
    check("rst_cv", 32'(cv4), 32'd0);
    check("rst_serv", 32'(serv4), 32'd0);
    do_reset();

    // Single source, claim on the following cycle.
    int_in = 4'b0100;
    step();
    check("one_cv", 32'(cv4), 32'd1);
    check("one_cid", 32'(cid4), 32'd2);
    claim_ready = 1;
    step();
    check("one_serv", 32'(serv4), 32'b0100);
    check("one_cv_after", 32'(cv4), 32'd0);

    // Priority between two simultaneous sources.
    do_reset();
    int_in = 4'b1010;
    step();
    check("prio_first", 32'(cid4), 32'd1);
    claim_ready = 1;
    int_in = '0;
    step();
    check("prio_second", 32'(cid4), 32'd3);

    // Complete while the input is still held high.
    do_reset();
    int_in = 4'b0001;
    step();
    claim_ready = 1;
    step();
    claim_ready = 0;
    complete_valid = 1; complete_id = 2'd0;
    step();
    check("relvl_idle", 32'(pend4[0]), 32'd0);
    complete_valid = 0;
    step();
`ifndef INT_GATEWAY_EDGE_EN
    check("relvl_pend", 32'(pend4[0]), 32'd1);
`endif

    // Completes aimed at an idle source, and at a source id that dut3 lacks.
    do_reset();
    complete_valid = 1; complete_id = 2'd2;
    step();
    check("bad_cmp_idle", 32'({pend4, serv4}), 32'd0);
    complete_valid = 0;
    int_in = 4'b0100;
    step();
    claim_ready = 1; int_in = '0;
    step();
    claim_ready = 0;
    complete_valid = 1; complete_id = 2'd3;
    step();
    check("bad_cmp_range", 32'(serv3), 32'b100);
    complete_valid = 0;

    // A claim and a complete in the same cycle.
    do_reset();
    int_in = 4'b0011;
    step();
    claim_ready = 1; int_in = '0;
    step();
    complete_valid = 1; complete_id = 2'd0;
    step();
    check("same_cyc_serv", 32'(serv4), 32'b0010);
    check("same_cyc_pend", 32'(pend4), 32'd0);
    idle_inputs();

`ifdef INT_GATEWAY_EDGE_EN
    // Two pulses during service collapse into one re-pend.
    do_reset();
    int_in = 4'b1000; step();
    int_in = '0; claim_ready = 1; step();
    claim_ready = 0;
    for (int p = 0; p < 2; p++) begin
      int_in = 4'b1000; step();
      int_in = '0; step();
    end
    complete_valid = 1; complete_id = 2'd3; step();
    check("edge_repend", 32'(pend4), 32'b1000);
    complete_valid = 0; claim_ready = 1; step();
    claim_ready = 0; complete_valid = 1; step();
    complete_valid = 0; step();
    check("edge_once", 32'({pend4, serv4}), 32'd0);
    int_in = 4'b1000; step();
    claim_ready = 1; step();
    idle_inputs(); reset = 1; step(); reset = 0;
    check("edge_rst", 32'({cv4, pend4, serv4}), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int_in = 4'($urandom);
      claim_ready = ($urandom_range(0, 2) != 0);
      complete_valid = ($urandom_range(0, 1) != 0);
      complete_id = 2'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_gateway_bank.md
INT_GATEWAY_BANK -- requirements
Module: int_gateway_bank

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of interrupt sources, legal range 2..16.
REQ-002 SHALL have parameter ID_W, default 2: claim/complete ID width, with NUM_SRC <= 2**ID_W.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port int_in, input, NUM_SRC: synchronized interrupt levels, one bit per source, from the async-crossing sink.
REQ-006 SHALL have port claim_valid, output, 1: at least one source is pending.
REQ-007 SHALL have port claim_id, output, ID_W: index of the offered source.
REQ-008 SHALL have port claim_ready, input, 1: consumer accepts the offered claim.
REQ-009 SHALL have port complete_valid, input, 1: consumer signals end of service.
REQ-010 SHALL have port complete_id, input, ID_W: source being completed.
REQ-011 SHALL have port pending, output, NUM_SRC: per-source PEND state, registered.
REQ-012 SHALL have port in_service, output, NUM_SRC: per-source SERV state, registered.

Function
REQ-013 SHALL run one FSM per source with states IDLE, PEND and SERV.
REQ-014 SHALL move a source from IDLE to PEND on the clock edge where its trigger is true (level mode: int_in[i]=1).
REQ-015 SHALL keep a source in PEND until it is claimed, even if int_in[i] deasserts.
REQ-016 SHALL drive claim_valid = OR of all PEND bits, combinationally from registered state.
REQ-017 SHALL drive claim_id = lowest index in PEND (fixed priority), or 0 when claim_valid=0.
REQ-018 SHALL move the source at claim_id from PEND to SERV on the next edge when claim_valid & claim_ready; no other source changes due to the claim.
REQ-019 SHALL ignore claim_ready while claim_valid=0.
REQ-020 SHALL move source complete_id from SERV to IDLE on the next edge when complete_valid=1 and that source is in SERV.
REQ-021 SHALL ignore a complete aimed at a source not in SERV, or with complete_id >= NUM_SRC; no state change.
REQ-022 SHALL apply a claim and a complete in the same cycle independently; they never target the same source.
REQ-023 SHALL give the following latency: int_in[i] rising at edge t produces pending[i]=1 and claim_valid=1 after edge t.
REQ-024 SHALL keep a source that completes with int_in still high in IDLE for exactly one cycle, then return it to PEND.
REQ-025 SHALL NOT retrigger a source whose input is still asserted while it is in PEND or SERV.

Reset
REQ-026 SHALL, while reset=1 at an edge, force all FSMs to IDLE, clear the edge history and edge latches, and drive claim_valid=0, claim_id=0, pending=0 and in_service=0.
REQ-027 SHALL, on reset mid-operation, discard outstanding claims; a later complete for a discarded source is ignored per REQ-021.
REQ-028 SHALL ignore int_in during reset; the first IDLE->PEND transition can occur at the first edge with reset=0.

Configuration
REQ-029 SHALL compile edge-triggered mode in when macro INT_GATEWAY_EDGE_EN is defined: trigger = int_in[i] & ~prev[i], where prev is a per-source register reset to 0 (so an input held high through reset yields one edge).
REQ-030 SHALL, with INT_GATEWAY_EDGE_EN defined, latch one rising edge per source (1-deep) arriving in PEND or SERV; on complete, a latched edge sends the source SERV->PEND directly and clears the latch; further edges while latched are dropped.
REQ-031 SHALL, without INT_GATEWAY_EDGE_EN, use level mode only (REQ-014, REQ-024) and contain no prev or latch registers.

Verification
REQ-032 SHALL verify: int_in=4'b0100 from cycle 1, claim_ready=1 at cycle 2 -> claim_valid=1, claim_id=2 at cycle 2; in_service=4'b0100 at cycle 3; claim_valid=0.
REQ-033 SHALL verify: int_in=4'b1010 together -> claim_id=1 first; after claiming it, claim_id=3 next cycle.
REQ-034 SHALL verify: source 0 in SERV, int_in[0] held 1, complete_id=0 -> IDLE for 1 cycle, then pending[0]=1.
REQ-035 SHALL verify: complete_valid=1, complete_id=2 while source 2 is IDLE -> no state change; complete_id=3 with NUM_SRC=3 -> ignored.
REQ-036 SHALL verify: same cycle, claim of source 1 and complete of source 0 -> after the edge, in_service=4'b0010, source 0 IDLE.
REQ-037 SHALL verify: with INT_GATEWAY_EDGE_EN defined, two pulses on int_in[3] while in SERV -> after complete, one re-PEND only; reset asserted mid-SERV -> all outputs 0 next cycle.
